// File: rtl/video_cr_bank.sv
// ---------------------------------------------------------------------------
// video_cr_bank
//
// Control-register bank for the multi-layer display controller. Decodes the
// BRAM-style register port coming from the AXI-lite slave bridge and holds the
// global CRT/timing registers plus NUM_LAYERS framebuffer register sets.
// Layer registers are double-buffered: software writes the shadow copy and the
// whole shadow set is copied to the active set at the next frame start once a
// commit has been requested. While the controller is disabled the active set
// simply follows the shadow set.
//
// Ports:
//   mem_clk, rst_ni     register clock, asynchronous active-low reset
//   mem_en, mem_we      access strobe and per-byte write enables
//   mem_addr            byte address (word index = mem_addr[ADDR_WIDTH-1:2])
//   mem_write           write data
//   mem_read            registered read data (1-cycle latency)
//   vsync_i             raw vsync from the pixel clock domain
//   irq_o               registered |(irq_status & irq_enable)
//   cr_enable_o         global enable
//   hsync_pol_o         hsync polarity
//   vsync_pol_o         vsync polarity
//   pxlfreq_o           pixel frequency select
//   crt_o               eight 16-bit CRT timing fields, LSB first
//   layer_*_o           active per-layer framebuffer settings, layer 0 in LSBs
// ---------------------------------------------------------------------------
module video_cr_bank #(
    parameter int NUM_LAYERS = 2,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                      mem_clk,
    input  logic                      rst_ni,
    input  logic                      mem_en,
    input  logic [3:0]                mem_we,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [31:0]               mem_write,
    output logic [31:0]               mem_read,
    input  logic                      vsync_i,
    output logic                      irq_o,
    output logic                      cr_enable_o,
    output logic                      hsync_pol_o,
    output logic                      vsync_pol_o,
    output logic [7:0]                pxlfreq_o,
    output logic [127:0]              crt_o,
    output logic [NUM_LAYERS-1:0]     layer_en_o,
    output logic [2*NUM_LAYERS-1:0]   layer_depth_o,
    output logic [64*NUM_LAYERS-1:0]  layer_base_o,
    output logic [12*NUM_LAYERS-1:0]  layer_width_o,
    output logic [12*NUM_LAYERS-1:0]  layer_height_o,
    output logic [14*NUM_LAYERS-1:0]  layer_bpl_o,
    output logic [24*NUM_LAYERS-1:0]  layer_bg_o,
    output logic [24*NUM_LAYERS-1:0]  layer_pos_o
);

    typedef struct packed {
        logic [63:0] base;
        logic        en;
        logic [1:0]  depth;
        logic [11:0] width;
        logic [11:0] height;
        logic [10:0] bpl;
        logic [23:0] bg;
        logic [23:0] pos;
    } layer_t;

    // h_total, h_end_disp, h_srt_sync, h_end_sync, v_total, v_end_disp,
    // v_srt_sync, v_end_sync packed LSB first (640x480 @ 60 Hz).
    localparam logic [127:0] CrtReset = {16'd492, 16'd490, 16'd480, 16'd525,
                                         16'd752, 16'd656, 16'd640, 16'd800};

    // Only layer 0 comes out of reset enabled. BPL is held in 8-byte units
    // because its low three bits are always zero (2048 bytes = 256).
    function automatic layer_t layerReset(input int n);
        layer_t r;
        r.base   = '0;
        r.en     = (n == 0);
        r.depth  = 2'd0;
        r.width  = 12'd640;
        r.height = 12'd480;
        r.bpl    = 11'd256;
        r.bg     = 24'hFFFFFF;
        r.pos    = '0;
        return r;
    endfunction

    // Replace only the enabled bytes of the current register value.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return r;
    endfunction

    logic [1:0]  rstSync_q;
    logic        rstInt_n;
    logic        vsMeta_q, vsSync_q, vsDly_q;
    logic        frameStart;

    logic        enable_q, enable_d;
    logic        hsyncPol_q, hsyncPol_d;
    logic        vsyncPol_q, vsyncPol_d;
    logic [7:0]  pxlfreq_q, pxlfreq_d;
    logic [127:0] crt_q, crt_d;
    logic [1:0]  irqStatus_q, irqStatus_d;
    logic [1:0]  irqEnable_q, irqEnable_d;
    logic        commitPending_q, commitPending_d;
    logic [15:0] frameCount_q, frameCount_d;
    logic        irq_q;
    logic [31:0] readData_q;

    layer_t      shadow_q [NUM_LAYERS];
    layer_t      shadow_d [NUM_LAYERS];
    layer_t      active_q [NUM_LAYERS];
    layer_t      active_d [NUM_LAYERS];

    logic [31:0] wordAddr;
    logic        wrEn;
    logic        commitSet;
    logic        isCrt;
    logic [NUM_LAYERS-1:0] layerHit;
    logic [31:0] rdData;
    logic [31:0] merged;
    logic        unusedAddrBits;

    assign wordAddr       = 32'(mem_addr[ADDR_WIDTH-1:2]);
    assign unusedAddrBits = ^mem_addr[1:0];
    assign wrEn           = mem_en && (|mem_we);
    assign commitSet      = wrEn && (wordAddr == 32'h05) && mem_we[0] && mem_write[0];
    assign isCrt          = (wordAddr[31:3] == 29'h2);

    // Reset release is re-timed to mem_clk; assertion stays asynchronous.
    always_ff @(posedge mem_clk or negedge rst_ni) begin
        if (!rst_ni) rstSync_q <= 2'b00;
        else         rstSync_q <= {rstSync_q[0], 1'b1};
    end
    assign rstInt_n = rstSync_q[1];

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge mem_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            vsMeta_q <= 1'b0;
            vsSync_q <= 1'b0;
            vsDly_q  <= 1'b0;
        end else begin
            vsMeta_q <= vsync_i;
            vsSync_q <= vsMeta_q;
            vsDly_q  <= vsSync_q;
        end
    end

    // The active vsync level is the inverse of the polarity bit.
    assign frameStart = (vsSync_q == !vsyncPol_q) && (vsDly_q != !vsyncPol_q);

    // Layer block decode: layer n occupies words 0x20+0x10*n .. +7.
    always_comb begin
        layerHit = '0;
        for (int n = 0; n < NUM_LAYERS; n++) begin
            layerHit[n] = (wordAddr[31:4] == 28'(n + 2)) && !wordAddr[3];
        end
    end

    // Read mux; unmapped words and out-of-range layers fall through as 0.
    always_comb begin
        rdData = '0;
        case (wordAddr)
            32'h00:  rdData = {31'd0, enable_q};
            32'h01:  rdData = {30'd0, vsyncPol_q, hsyncPol_q};
            32'h02:  rdData = {24'd0, pxlfreq_q};
            32'h03:  rdData = {30'd0, irqStatus_q};
            32'h04:  rdData = {30'd0, irqEnable_q};
            32'h05:  rdData = {31'd0, commitPending_q};
            32'h06:  rdData = {16'd0, frameCount_q};
            default: rdData = '0;
        endcase
        if (isCrt) begin
            rdData = {16'd0, crt_q[{wordAddr[2:0], 4'd0} +: 16]};
        end
        for (int n = 0; n < NUM_LAYERS; n++) begin
            if (layerHit[n]) begin
                case (wordAddr[2:0])
                    3'd0:    rdData = shadow_q[n].base[31:0];
                    3'd1:    rdData = shadow_q[n].base[63:32];
                    3'd2:    rdData = {29'd0, shadow_q[n].depth, shadow_q[n].en};
                    3'd3:    rdData = {20'd0, shadow_q[n].width};
                    3'd4:    rdData = {20'd0, shadow_q[n].height};
                    3'd5:    rdData = {18'd0, shadow_q[n].bpl, 3'd0};
                    3'd6:    rdData = {8'd0, shadow_q[n].bg};
                    default: rdData = {8'd0, shadow_q[n].pos};
                endcase
            end
        end
    end

    // Next-state logic. Register writes are applied first; frame events are
    // then layered on top so that hardware sets beat W1C clears and a commit
    // copies the pre-write shadow (shadow_q) into the active set.
    always_comb begin
        enable_d        = enable_q;
        hsyncPol_d      = hsyncPol_q;
        vsyncPol_d      = vsyncPol_q;
        pxlfreq_d       = pxlfreq_q;
        crt_d           = crt_q;
        irqStatus_d     = irqStatus_q;
        irqEnable_d     = irqEnable_q;
        commitPending_d = commitPending_q | commitSet;
        frameCount_d    = frameCount_q;
        shadow_d        = shadow_q;
        active_d        = active_q;
        merged          = mergeBytes(rdData, mem_write, mem_we);

        if (wrEn) begin
            case (wordAddr)
                32'h00: enable_d = merged[0];
                32'h01: begin
                    if (!enable_q) begin
                        hsyncPol_d = merged[0];
                        vsyncPol_d = merged[1];
                    end
                end
                32'h02: begin
                    if (!enable_q) pxlfreq_d = merged[7:0];
                end
                32'h03: begin
                    if (mem_we[0]) irqStatus_d = irqStatus_q & ~mem_write[1:0];
                end
                32'h04: irqEnable_d = merged[1:0];
                default: ;
            endcase
            if (isCrt && !enable_q) begin
                crt_d[{wordAddr[2:0], 4'd0} +: 16] = merged[15:0];
            end
            for (int n = 0; n < NUM_LAYERS; n++) begin
                if (layerHit[n]) begin
                    case (wordAddr[2:0])
                        3'd0: shadow_d[n].base[31:0]  = merged;
                        3'd1: shadow_d[n].base[63:32] = merged;
                        3'd2: begin
                            shadow_d[n].en    = merged[0];
                            shadow_d[n].depth = (merged[2:1] == 2'd3) ? 2'd0 : merged[2:1];
                        end
                        3'd3: shadow_d[n].width  = merged[11:0];
                        3'd4: shadow_d[n].height = merged[11:0];
                        3'd5: shadow_d[n].bpl    = merged[13:3];
                        3'd6: shadow_d[n].bg     = merged[23:0];
                        default: shadow_d[n].pos = merged[23:0];
                    endcase
                end
            end
        end

        if (enable_q) begin
            if (frameStart) begin
                irqStatus_d[1] = 1'b1;
                frameCount_d   = frameCount_q + 16'd1;
                if (commitPending_q) begin
                    active_d        = shadow_q;
                    irqStatus_d[0]  = 1'b1;
                    commitPending_d = commitSet;
                end
            end
        end else begin
            active_d        = shadow_q;
            commitPending_d = 1'b0;
        end
    end

    // All architectural state, including the registered read data and irq.
    always_ff @(posedge mem_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            enable_q        <= 1'b0;
            hsyncPol_q      <= 1'b1;
            vsyncPol_q      <= 1'b1;
            pxlfreq_q       <= 8'd25;
            crt_q           <= CrtReset;
            irqStatus_q     <= 2'b00;
            irqEnable_q     <= 2'b00;
            commitPending_q <= 1'b0;
            frameCount_q    <= 16'd0;
            irq_q           <= 1'b0;
            readData_q      <= 32'd0;
            for (int n = 0; n < NUM_LAYERS; n++) begin
                shadow_q[n] <= layerReset(n);
                active_q[n] <= layerReset(n);
            end
        end else begin
            enable_q        <= enable_d;
            hsyncPol_q      <= hsyncPol_d;
            vsyncPol_q      <= vsyncPol_d;
            pxlfreq_q       <= pxlfreq_d;
            crt_q           <= crt_d;
            irqStatus_q     <= irqStatus_d;
            irqEnable_q     <= irqEnable_d;
            commitPending_q <= commitPending_d;
            frameCount_q    <= frameCount_d;
            irq_q           <= |(irqStatus_q & irqEnable_q);
            if (mem_en) readData_q <= rdData;
            shadow_q        <= shadow_d;
            active_q        <= active_d;
        end
    end

    assign mem_read    = readData_q;
    assign irq_o       = irq_q;
    assign cr_enable_o = enable_q;
    assign hsync_pol_o = hsyncPol_q;
    assign vsync_pol_o = vsyncPol_q;
    assign pxlfreq_o   = pxlfreq_q;
    assign crt_o       = crt_q;

    for (genvar n = 0; n < NUM_LAYERS; n++) begin : gLayerOut
        assign layer_en_o[n]              = active_q[n].en;
        assign layer_depth_o[2*n +: 2]    = active_q[n].depth;
        assign layer_base_o[64*n +: 64]   = active_q[n].base;
        assign layer_width_o[12*n +: 12]  = active_q[n].width;
        assign layer_height_o[12*n +: 12] = active_q[n].height;
        assign layer_bpl_o[14*n +: 14]    = {active_q[n].bpl, 3'd0};
        assign layer_bg_o[24*n +: 24]     = active_q[n].bg;
        assign layer_pos_o[24*n +: 24]    = active_q[n].pos;
    end

endmodule

// File: tb/tb_video_cr_bank.sv
// ---------------------------------------------------------------------------
// tb_video_cr_bank
//
// Directed self-checking bench for video_cr_bank with the default two layers.
// Every task is entered and left on a falling mem_clk edge, so inputs change
// half a cycle away from the sampling edge and outputs are read there too.
// ---------------------------------------------------------------------------
module tb_video_cr_bank;

    localparam int NL = 2;
    localparam int AW = 12;
    localparam logic [127:0] CrtReset = {16'd492, 16'd490, 16'd480, 16'd525,
                                         16'd752, 16'd656, 16'd640, 16'd800};

    logic              mem_clk = 1'b0;
    logic              rst_ni;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_write;
    logic [31:0]       mem_read;
    logic              vsync_i;
    logic              irq_o;
    logic              cr_enable_o;
    logic              hsync_pol_o;
    logic              vsync_pol_o;
    logic [7:0]        pxlfreq_o;
    logic [127:0]      crt_o;
    logic [NL-1:0]     layer_en_o;
    logic [2*NL-1:0]   layer_depth_o;
    logic [64*NL-1:0]  layer_base_o;
    logic [12*NL-1:0]  layer_width_o;
    logic [12*NL-1:0]  layer_height_o;
    logic [14*NL-1:0]  layer_bpl_o;
    logic [24*NL-1:0]  layer_bg_o;
    logic [24*NL-1:0]  layer_pos_o;

    int errCount   = 0;
    int checkCount = 0;

    video_cr_bank #(.NUM_LAYERS(NL), .ADDR_WIDTH(AW)) dut (
        .mem_clk(mem_clk), .rst_ni(rst_ni), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .vsync_i(vsync_i), .irq_o(irq_o), .cr_enable_o(cr_enable_o),
        .hsync_pol_o(hsync_pol_o), .vsync_pol_o(vsync_pol_o),
        .pxlfreq_o(pxlfreq_o), .crt_o(crt_o), .layer_en_o(layer_en_o),
        .layer_depth_o(layer_depth_o), .layer_base_o(layer_base_o),
        .layer_width_o(layer_width_o), .layer_height_o(layer_height_o),
        .layer_bpl_o(layer_bpl_o), .layer_bg_o(layer_bg_o),
        .layer_pos_o(layer_pos_o)
    );

    always #5 mem_clk = ~mem_clk;

    // One write cycle, sampled on the next rising edge.
    task automatic writeReg(input int word, input logic [31:0] data, input logic [3:0] be);
        mem_en    = 1'b1;
        mem_we    = be;
        mem_addr  = AW'(word * 4);
        mem_write = data;
        @(negedge mem_clk);
        mem_en = 1'b0;
        mem_we = 4'd0;
    endtask

    // One read cycle; data is captured one cycle after the strobe.
    task automatic readReg(input int word, output logic [31:0] data);
        mem_en   = 1'b1;
        mem_we   = 4'd0;
        mem_addr = AW'(word * 4);
        @(negedge mem_clk);
        mem_en = 1'b0;
        data   = mem_read;
    endtask

    task automatic test_reset;
        int          rWord [30];
        logic [31:0] rExp  [30];
        logic [31:0] rd;
        rWord = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h10, 'h11, 'h12,
                  'h13, 'h14, 'h15, 'h16, 'h17, 'h20, 'h21, 'h22, 'h23, 'h24,
                  'h25, 'h26, 'h27, 'h32, 'h33, 'h36, 'h07, 'h18, 'h28, 'h40};
        rExp  = '{32'd0, 32'd3, 32'd25, 32'd0, 32'd0, 32'd0, 32'd0, 32'd800, 32'd640, 32'd656,
                  32'd752, 32'd525, 32'd480, 32'd490, 32'd492, 32'd0, 32'd0, 32'd1, 32'd640, 32'd480,
                  32'd2048, 32'hFFFFFF, 32'd0, 32'd0, 32'd640, 32'hFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        rst_ni = 1'b0;
        repeat (3) @(negedge mem_clk);
        checkCount++;
        if ({irq_o, cr_enable_o, hsync_pol_o, vsync_pol_o, pxlfreq_o} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'd25}) begin
            errCount++;
            $display("[TB] FAIL reset_globals: got irq=%b en=%b hp=%b vp=%b pf=%0d required 0 0 1 1 25",
                     irq_o, cr_enable_o, hsync_pol_o, vsync_pol_o, pxlfreq_o);
        end
        rst_ni = 1'b1;
        repeat (4) @(negedge mem_clk);
        checkCount++;
        if (crt_o !== CrtReset || mem_read !== 32'd0) begin
            errCount++;
            $display("[TB] FAIL reset_crt_read: got crt=%h rd=%h required crt=%h rd=0", crt_o, mem_read, CrtReset);
        end
        checkCount++;
        if (layer_en_o !== 2'b01 || layer_depth_o !== 4'd0 || layer_base_o !== 128'd0 || layer_pos_o !== 48'd0) begin
            errCount++;
            $display("[TB] FAIL reset_layer_a: got en=%b depth=%h base=%h pos=%h required en=01 rest 0",
                     layer_en_o, layer_depth_o, layer_base_o, layer_pos_o);
        end
        checkCount++;
        if (layer_width_o !== {12'd640, 12'd640} || layer_height_o !== {12'd480, 12'd480} ||
            layer_bpl_o !== {14'd2048, 14'd2048} || layer_bg_o !== {24'hFFFFFF, 24'hFFFFFF}) begin
            errCount++;
            $display("[TB] FAIL reset_layer_b: got w=%h h=%h bpl=%h bg=%h required 640/480/2048/ffffff per layer",
                     layer_width_o, layer_height_o, layer_bpl_o, layer_bg_o);
        end
        for (int i = 0; i < 30; i++) begin
            readReg(rWord[i], rd);
            checkCount++;
            if (rd !== rExp[i]) begin
                errCount++;
                $display("[TB] FAIL reset_read word 0x%0h: got %0h required %0h", rWord[i], rd, rExp[i]);
            end
        end
    endtask

    task automatic test_crt_lock;
        logic [31:0] rd;
        writeReg('h00, 32'd1, 4'hF);
        writeReg('h10, 32'd1024, 4'hF);
        readReg('h10, rd);
        checkCount++;
        if (rd !== 32'd800 || crt_o[15:0] !== 16'd800) begin
            errCount++;
            $display("[TB] FAIL crt_locked: got rd=%0d crt=%0d required 800/800", rd, crt_o[15:0]);
        end
        writeReg('h00, 32'd0, 4'hF);
        writeReg('h10, 32'd1024, 4'hF);
        readReg('h10, rd);
        checkCount++;
        if (rd !== 32'd1024 || crt_o[15:0] !== 16'd1024) begin
            errCount++;
            $display("[TB] FAIL crt_unlocked: got rd=%0d crt=%0d required 1024/1024", rd, crt_o[15:0]);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd;
        writeReg('h26, 32'hAABBCCDD, 4'b0010);
        readReg('h26, rd);
        checkCount++;
        if (rd !== 32'hFFCCFF || layer_bg_o[23:0] !== 24'hFFCCFF) begin
            errCount++;
            $display("[TB] FAIL bg_byte_enable: got rd=%h out=%h required ffccff", rd, layer_bg_o[23:0]);
        end
        writeReg('h23, 32'hFFFFFFFF, 4'hF);
        readReg('h23, rd);
        checkCount++;
        if (rd !== 32'hFFF) begin
            errCount++;
            $display("[TB] FAIL width_trunc: got %h required fff", rd);
        end
        writeReg('h25, 32'h12345677, 4'hF);
        readReg('h25, rd);
        checkCount++;
        if (rd !== 32'h1670 || layer_bpl_o[13:0] !== 14'h1670) begin
            errCount++;
            $display("[TB] FAIL bpl_trunc: got rd=%h out=%h required 1670", rd, layer_bpl_o[13:0]);
        end
        writeReg('h22, 32'd7, 4'hF);
        readReg('h22, rd);
        checkCount++;
        if (rd !== 32'd1) begin
            errCount++;
            $display("[TB] FAIL depth_reserved: got %h required 1", rd);
        end
        writeReg('h22, 32'd5, 4'hF);
        readReg('h22, rd);
        checkCount++;
        if (rd !== 32'd5 || layer_depth_o[1:0] !== 2'd2 || layer_en_o[0] !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL depth_grey: got rd=%h depth=%0d en=%b required 5/2/1", rd, layer_depth_o[1:0], layer_en_o[0]);
        end
        writeReg('h40, 32'd1234, 4'hF);
        readReg('h40, rd);
        checkCount++;
        if (rd !== 32'd0) begin
            errCount++;
            $display("[TB] FAIL unmapped_layer: got %h required 0", rd);
        end
        writeReg('h36, 32'h00123456, 4'hF);
        readReg('h36, rd);
        checkCount++;
        if (rd !== 32'h123456 || layer_bg_o[47:24] !== 24'h123456 || layer_bg_o[23:0] !== 24'hFFCCFF) begin
            errCount++;
            $display("[TB] FAIL layer1_bg: got rd=%h out=%h required 123456/123456ffccff", rd, layer_bg_o);
        end
    endtask

    task automatic test_commit;
        logic [31:0] rd;
        int          edges;
        writeReg('h00, 32'd1, 4'hF);
        writeReg('h20, 32'h1000, 4'hF);
        readReg('h05, rd);
        checkCount++;
        if (layer_base_o[31:0] !== 32'd0) begin
            errCount++;
            $display("[TB] FAIL base_held: got %h required 0", layer_base_o[31:0]);
        end
        writeReg('h05, 32'd1, 4'hF);
        readReg('h05, rd);
        checkCount++;
        if (rd !== 32'd1) begin
            errCount++;
            $display("[TB] FAIL commit_pending_set: got %h required 1", rd);
        end
        vsync_i = 1'b0;
        edges   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge mem_clk);
            if (layer_base_o[31:0] === 32'h1000) begin
                edges = k;
                break;
            end
        end
        checkCount++;
        if (edges < 3 || edges > 4) begin
            errCount++;
            $display("[TB] FAIL commit_latency: got %0d edges (0 = never) required 3..4", edges);
        end
        vsync_i = 1'b1;
        repeat (3) @(negedge mem_clk);
        readReg('h03, rd);
        checkCount++;
        if (rd !== 32'd3) begin
            errCount++;
            $display("[TB] FAIL irq_status_after_commit: got %h required 3", rd);
        end
        readReg('h05, rd);
        checkCount++;
        if (rd !== 32'd0) begin
            errCount++;
            $display("[TB] FAIL commit_cleared: got %h required 0", rd);
        end
        readReg('h06, rd);
        checkCount++;
        if (rd !== 32'd1) begin
            errCount++;
            $display("[TB] FAIL frame_count_one: got %0d required 1", rd);
        end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        writeReg('h03, 32'd3, 4'hF);
        readReg('h03, rd);
        checkCount++;
        if (rd !== 32'd0 || irq_o !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL irq_w1c: got status=%h irq=%b required 0/0", rd, irq_o);
        end
        writeReg('h04, 32'd1, 4'hF);
        writeReg('h20, 32'h2000, 4'hF);
        writeReg('h05, 32'd1, 4'hF);
        vsync_i = 1'b0;
        repeat (3) @(negedge mem_clk);
        checkCount++;
        if (layer_base_o[31:0] !== 32'h2000 || irq_o !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL irq_commit_edge: got base=%h irq=%b required 2000/0", layer_base_o[31:0], irq_o);
        end
        @(negedge mem_clk);
        checkCount++;
        if (irq_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL irq_raised: got %b required 1", irq_o);
        end
        vsync_i = 1'b1;
        repeat (3) @(negedge mem_clk);
        writeReg('h20, 32'h3000, 4'hF);
        writeReg('h05, 32'd1, 4'hF);
        vsync_i = 1'b0;
        repeat (2) @(negedge mem_clk);
        writeReg('h03, 32'd1, 4'hF);
        readReg('h03, rd);
        checkCount++;
        if (rd !== 32'd3 || layer_base_o[31:0] !== 32'h3000) begin
            errCount++;
            $display("[TB] FAIL irq_set_beats_w1c: got status=%h base=%h required 3/3000", rd, layer_base_o[31:0]);
        end
        checkCount++;
        if (irq_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL irq_held: got %b required 1", irq_o);
        end
        vsync_i = 1'b1;
        repeat (3) @(negedge mem_clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        writeReg('h20, 32'h4000, 4'hF);
        writeReg('h05, 32'd1, 4'hF);
        vsync_i = 1'b0;
        repeat (2) @(negedge mem_clk);
        writeReg('h05, 32'd1, 4'hF);
        readReg('h05, rd);
        checkCount++;
        if (rd !== 32'd1 || layer_base_o[31:0] !== 32'h4000) begin
            errCount++;
            $display("[TB] FAIL commit_write_same_cycle: got pending=%h base=%h required 1/4000", rd, layer_base_o[31:0]);
        end
        vsync_i = 1'b1;
        repeat (3) @(negedge mem_clk);
        vsync_i = 1'b0;
        repeat (2) @(negedge mem_clk);
        writeReg('h20, 32'h5000, 4'hF);
        readReg('h20, rd);
        checkCount++;
        if (rd !== 32'h5000 || layer_base_o[31:0] !== 32'h4000) begin
            errCount++;
            $display("[TB] FAIL shadow_write_same_cycle: got shadow=%h active=%h required 5000/4000", rd, layer_base_o[31:0]);
        end
        readReg('h05, rd);
        checkCount++;
        if (rd !== 32'd0) begin
            errCount++;
            $display("[TB] FAIL pending_after_second: got %h required 0", rd);
        end
        vsync_i = 1'b1;
        repeat (3) @(negedge mem_clk);
    endtask

    task automatic test_frame_count;
        logic [31:0] rd;
        readReg('h06, rd);
        checkCount++;
        if (rd !== 32'd5) begin
            errCount++;
            $display("[TB] FAIL frame_count_five: got %0d required 5", rd);
        end
        for (int i = 0; i < 600; i++) begin
            vsync_i = ~vsync_i;
            @(negedge mem_clk);
        end
        repeat (3) @(negedge mem_clk);
        readReg('h06, rd);
        checkCount++;
        if (rd !== 32'd305) begin
            errCount++;
            $display("[TB] FAIL frame_count_run: got %0d required 305", rd);
        end
        writeReg('h00, 32'd0, 4'hF);
        for (int i = 0; i < 40; i++) begin
            vsync_i = ~vsync_i;
            @(negedge mem_clk);
        end
        repeat (3) @(negedge mem_clk);
        readReg('h06, rd);
        checkCount++;
        if (rd !== 32'd305 || cr_enable_o !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL frame_count_disabled: got %0d en=%b required 305/0", rd, cr_enable_o);
        end
    endtask

    task automatic test_enable_tracking;
        checkCount++;
        if (layer_base_o[31:0] !== 32'h5000) begin
            errCount++;
            $display("[TB] FAIL track_base: got %h required 5000", layer_base_o[31:0]);
        end
        writeReg('h27, 32'h00ABC123, 4'hF);
        checkCount++;
        if (layer_pos_o[23:0] !== 24'd0) begin
            errCount++;
            $display("[TB] FAIL track_pos_early: got %h required 0", layer_pos_o[23:0]);
        end
        @(negedge mem_clk);
        checkCount++;
        if (layer_pos_o[23:0] !== 24'hABC123) begin
            errCount++;
            $display("[TB] FAIL track_pos: got %h required abc123", layer_pos_o[23:0]);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] rd;
        writeReg('h00, 32'd1, 4'hF);
        readReg('h06, rd);
        checkCount++;
        if (cr_enable_o !== 1'b1 || mem_read !== 32'd305) begin
            errCount++;
            $display("[TB] FAIL pre_reset: got en=%b rd=%0d required 1/305", cr_enable_o, mem_read);
        end
        #3 rst_ni = 1'b0;
        #1;
        checkCount++;
        if (cr_enable_o !== 1'b0 || mem_read !== 32'd0 || crt_o !== CrtReset ||
            layer_base_o[31:0] !== 32'd0 || layer_pos_o[23:0] !== 24'd0) begin
            errCount++;
            $display("[TB] FAIL async_reset: got en=%b rd=%h crt0=%0d base=%h pos=%h required 0/0/800/0/0",
                     cr_enable_o, mem_read, crt_o[15:0], layer_base_o[31:0], layer_pos_o[23:0]);
        end
        @(negedge mem_clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge mem_clk);
        readReg('h10, rd);
        checkCount++;
        if (rd !== 32'd800) begin
            errCount++;
            $display("[TB] FAIL post_reset_crt: got %0d required 800", rd);
        end
    endtask

    // Scenario sequence; each task leaves the bench on a falling edge.
    initial begin
        rst_ni    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'd0;
        mem_addr  = '0;
        mem_write = 32'd0;
        vsync_i   = 1'b1;
        $display("[TB] starting video_cr_bank bench");
        test_reset;
        test_crt_lock;
        test_byte_enable;
        test_commit;
        test_irq;
        test_back_to_back;
        test_frame_count;
        test_enable_tracking;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
